// File: rtl/iter_bit_alu_pkg.sv
// Shared opcode encoding and width helpers for the iterative bit-scan ALU.
package iter_bit_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_OR   = 4'd2,
    OP_CMCO = 4'd3,
    OP_RSON = 4'd4,
    OP_POPC = 4'd5,
    OP_CLZ  = 4'd6
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } alu_state_e;

  // Bits needed to hold a bit index 0..w-1 (at least one bit).
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Bits needed to hold a count 0..w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bitscan_step.sv
// Combinational single-chunk update of the run/max/popcount/parity/last-set-bit scan state.
module bitscan_step
  import iter_bit_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0]        chunk,
  input  logic [idx_w(WIDTH)-1:0] base,
  input  logic [cnt_w(WIDTH)-1:0] run,
  input  logic [cnt_w(WIDTH)-1:0] maxrun,
  input  logic [cnt_w(WIDTH)-1:0] pop,
  input  logic                    par,
  input  logic [idx_w(WIDTH)-1:0] hi_idx,
  input  logic                    hi_seen,
  output logic [cnt_w(WIDTH)-1:0] run_nx,
  output logic [cnt_w(WIDTH)-1:0] maxrun_nx,
  output logic [cnt_w(WIDTH)-1:0] pop_nx,
  output logic                    par_nx,
  output logic [idx_w(WIDTH)-1:0] hi_idx_nx,
  output logic                    hi_seen_nx
);

  localparam int IW = idx_w(WIDTH);

  always_comb begin
    run_nx     = run;
    maxrun_nx  = maxrun;
    pop_nx     = pop;
    par_nx     = par;
    hi_idx_nx  = hi_idx;
    hi_seen_nx = hi_seen;
    // LSB first, so the run entering this chunk continues the previous chunk's top bits.
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        run_nx     = run_nx + 1'b1;
        pop_nx     = pop_nx + 1'b1;
        par_nx     = ~par_nx;
        hi_idx_nx  = base + IW'(i);
        hi_seen_nx = 1'b1;
      end else begin
        run_nx = '0;
      end
      if (run_nx > maxrun_nx) maxrun_nx = run_nx;
    end
  end

endmodule

// File: rtl/iter_bit_alu.sv
// Multi-cycle EX-stage ALU: single-cycle ADD/SUB/OR, chunked bit-scan ops behind start/busy/done.
module iter_bit_alu
  import iter_bit_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = idx_w(WIDTH);
  localparam int RW = cnt_w(WIDTH);

  alu_state_e       state;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    run, maxrun, pop;
  logic             par, hi_seen;
  logic [IW-1:0]    hi_idx;

  logic [IW-1:0]    base;
  logic [RW-1:0]    run_nx, maxrun_nx, pop_nx;
  logic             par_nx, hi_seen_nx;
  logic [IW-1:0]    hi_idx_nx;

  assign base = IW'(int'(cnt) * CHUNK);

  bitscan_step #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) u_step (
    .chunk      (a_q[base +: CHUNK]),
    .base       (base),
    .run        (run),
    .maxrun     (maxrun),
    .pop        (pop),
    .par        (par),
    .hi_idx     (hi_idx),
    .hi_seen    (hi_seen),
    .run_nx     (run_nx),
    .maxrun_nx  (maxrun_nx),
    .pop_nx     (pop_nx),
    .par_nx     (par_nx),
    .hi_idx_nx  (hi_idx_nx),
    .hi_seen_nx (hi_seen_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      cnt     <= '0;
      run     <= '0;
      maxrun  <= '0;
      pop     <= '0;
      par     <= 1'b0;
      hi_idx  <= '0;
      hi_seen <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (alu_op_e'(op))
              OP_ADD: begin result <= a + b; done <= 1'b1; end
              OP_SUB: begin result <= a - b; done <= 1'b1; end
              OP_OR:  begin result <= a | b; done <= 1'b1; end
              OP_CMCO, OP_RSON, OP_POPC, OP_CLZ: begin
                op_q    <= alu_op_e'(op);
                a_q     <= a;
                cnt     <= '0;
                run     <= '0;
                maxrun  <= '0;
                pop     <= '0;
                par     <= 1'b0;
                hi_idx  <= '0;
                hi_seen <= 1'b0;
                busy    <= 1'b1;
                state   <= ST_SCAN;
              end
              default: begin result <= '0; done <= 1'b1; end
            endcase
          end
        end
        ST_SCAN: begin
          run     <= run_nx;
          maxrun  <= maxrun_nx;
          pop     <= pop_nx;
          par     <= par_nx;
          hi_idx  <= hi_idx_nx;
          hi_seen <= hi_seen_nx;
          if (cnt == CW'(N - 1)) begin
            // The final chunk's update feeds the result directly on the completion edge.
            case (op_q)
              OP_CMCO: result <= WIDTH'(maxrun_nx);
              OP_RSON: result <= WIDTH'(par_nx);
              OP_POPC: result <= WIDTH'(pop_nx);
              OP_CLZ:  result <= hi_seen_nx ? WIDTH'(WIDTH - 1 - int'(hi_idx_nx))
                                            : WIDTH'(WIDTH);
              default: result <= '0;
            endcase
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_bit_alu.sv
// Directed self-checking bench for iter_bit_alu at WIDTH=32, CHUNK=4.
module tb_iter_bit_alu;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] ORR  = 4'd2;
  localparam logic [3:0] CMCO = 4'd3;
  localparam logic [3:0] RSON = 4'd4;
  localparam logic [3:0] POPC = 4'd5;
  localparam logic [3:0] CLZ  = 4'd6;
  localparam logic [3:0] BAD  = 4'd15;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  iter_bit_alu #(
    .WIDTH (32),
    .CHUNK (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept a scan op, check busy/done through the 8 scan edges, then the result and done drop.
  task automatic do_scan(input logic [3:0] o, input logic [31:0] av,
                         input logic [31:0] exp, input string tag);
    op = o; a = av; b = '0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_result"}, result, exp);
    tick();
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic do_single(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp, input string tag);
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_result"}, result, exp);
    tick();
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;
    tick();

    do_single(ADD, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, "add_wrap");
    do_single(SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub_neg");
    do_single(ORR, 32'hF0F0_0000, 32'h0000_F0F1, 32'hF0F0_F0F1, "or");
    do_single(BAD, 32'h1234_5678, 32'h1, 32'h0000_0000, "undef_op");

    do_scan(CMCO, 32'h0F0F_FF01, 32'd12, "cmco");
    do_scan(POPC, 32'h0F0F_FF01, 32'd17, "popc");
    do_scan(RSON, 32'h0F0F_FF01, 32'd1, "rson");
    do_scan(CLZ,  32'h0F0F_FF01, 32'd4, "clz");
    do_scan(CLZ,  32'h0000_0000, 32'd32, "clz_zero");
    do_scan(CMCO, 32'hFFFF_FFFF, 32'd32, "cmco_ones");
    do_scan(POPC, 32'hFFFF_FFFF, 32'd32, "popc_ones");
    do_scan(CMCO, 32'h0000_0000, 32'd0, "cmco_zero");
    do_scan(RSON, 32'h0000_0003, 32'd0, "rson_even");
    do_scan(CLZ,  32'h8000_0000, 32'd0, "clz_msb");
    do_scan(CLZ,  32'h0000_0001, 32'd31, "clz_lsb");

    // start with ADD during a CMCO scan must be ignored
    op = CMCO; a = 32'h0F0F_FF01; b = '0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    op = ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_nodone", 32'(done), 32'd0);
    for (int i = 4; i < 8; i++) begin
      tick();
      check("ign_nodone_scan", 32'(done), 32'd0);
    end
    tick();
    check("ign_done", 32'(done), 32'd1);
    check("ign_result", result, 32'd12);
    tick();
    check("ign_single_done", 32'(done), 32'd0);
    check("ign_hold", result, 32'd12);

    // reset three edges into a POPC aborts it
    op = POPC; a = 32'h0F0F_FF01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    do_scan(POPC, 32'h0F0F_FF01, 32'd17, "popc_after_abort");

    // back-to-back: start held through done; new operands while busy are not sampled
    op = CMCO; a = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    op = POPC; a = 32'h0F0F_FF01;
    for (int i = 0; i < 7; i++) tick();
    check("b2b_first_nodone", 32'(done), 32'd0);
    tick();
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_idle", 32'(busy), 32'd0);
    check("b2b_first_result", result, 32'd32);
    tick();
    start = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    check("b2b_second_nodone", 32'(done), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check("b2b_second_wait", 32'(done), 32'd0);
    tick();
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_result", result, 32'd17);
    tick();
    check("b2b_second_pulse", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
